// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and small helpers
// used by the transmitter and its FIFO (and later by the receiver).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Widest data word any UART in this library supports.
  localparam int MAX_DATA_BITS = 9;

  // Parity bit for a word that is zero-extended to MAX_DATA_BITS; the padding
  // zeros do not change the XOR reduction.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int mode);
    return (mode == PAR_EVEN) ? (^data) : ~(^data);
  endfunction

  // True for 1, 2, 4, 8, ...
  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers carry one extra MSB so
// that full and empty can be told apart when the index bits are equal.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  // Status flags and the head word, all straight from the registered pointers.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next storage/pointer values; a push when full or a pop when empty is dropped.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Register storage and pointers; reset only flushes the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter fed from an input FIFO. Frames are start bit,
// DATA_BITS data bits LSB-first, optional parity, then 1 or 2 stop bits; a
// queued word starts on the same edge the previous stop bit ends.
// The line, tx_active and tx_done are registered one cycle behind the FSM so
// the pin never glitches.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FREQUENCY  = 10000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_serial,
  output logic                          tx_active,
  output logic                          tx_done
);

  localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
  localparam uart_state_e   AFTER_DATA = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_cfg: FREQUENCY/BAUD_RATE must be at least 2");
  end

  uart_state_e            state_q;
  uart_state_e            state_d;
  logic [CW-1:0]          baud_cnt_q;
  logic [CW-1:0]          baud_cnt_d;
  logic [BW-1:0]          bit_idx_q;
  logic [BW-1:0]          bit_idx_d;
  logic                   stop_cnt_q;
  logic                   stop_cnt_d;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic                   done_pend_q;
  logic                   done_pend_d;
  logic                   tx_serial_q;
  logic                   tx_serial_d;
  logic                   tx_active_q;
  logic                   tx_active_d;
  logic                   tx_done_q;
  logic                   tx_done_d;

  logic                   baud_last;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_head;
  logic [MAX_DATA_BITS-1:0] par_data;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_ready  = ~fifo_full;
  assign tx_serial = tx_serial_q;
  assign tx_active = tx_active_q;
  assign tx_done   = tx_done_q;
  assign baud_last = (baud_cnt_q == BAUD_LAST);

  // FSM next state: bit timing, bit/stop counters and FIFO pops at frame boundaries.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    done_pend_d = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            state_d   = AFTER_DATA;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = ST_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d  = 1'b0;
            done_pend_d = 1'b1;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_head;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level and status for the current state, registered on the next edge.
  always_comb begin
    par_data                = '0;
    par_data[DATA_BITS-1:0] = shift_q;
    unique case (state_q)
      ST_IDLE:   tx_serial_d = 1'b1;
      ST_START:  tx_serial_d = 1'b0;
      ST_DATA:   tx_serial_d = shift_q[bit_idx_q];
      ST_PARITY: tx_serial_d = parity_bit(par_data, PARITY);
      ST_STOP:   tx_serial_d = 1'b1;
      default:   tx_serial_d = 1'b1;
    endcase
    tx_active_d = (state_q != ST_IDLE);
    tx_done_d   = done_pend_q;
  end

  // All transmitter state; reset drops any partial frame and idles the line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      done_pend_q <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      done_pend_q <= done_pend_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 7E2, 7O2, 9N1) at 10 clocks per
// bit. A vector table holds hand-built frames checked cycle-accurately; hand
// sequences cover FIFO fill, same-edge push/pop and mid-frame reset.
module tb_uart_tx_cfg;

  localparam int FREQ = 1000000;
  localparam int BAUD = 100000;
  localparam int CPB  = 10;

  typedef struct {
    int         inst;
    logic [8:0] word;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [3:0]      valid;
  logic [3:0][8:0] data;
  logic [3:0]      rdy;
  logic [3:0]      ser;
  logic [3:0]      act;
  logic [3:0]      done;
  logic [3:0][2:0] cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] mon_words [64];
  int mon_wr      = 0;
  int done_cnt_a  = 0;
  int act_hi_a    = 0;
  int act_rise_a  = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.FREQUENCY(FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
    .tx_ready(rdy[0]), .fifo_count(cnt[0]), .tx_serial(ser[0]),
    .tx_active(act[0]), .tx_done(done[0]));

  uart_tx_cfg #(.FREQUENCY(FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid[1]), .tx_data(data[1][6:0]),
    .tx_ready(rdy[1]), .fifo_count(cnt[1]), .tx_serial(ser[1]),
    .tx_active(act[1]), .tx_done(done[1]));

  uart_tx_cfg #(.FREQUENCY(FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid[2]), .tx_data(data[2][6:0]),
    .tx_ready(rdy[2]), .fifo_count(cnt[2]), .tx_serial(ser[2]),
    .tx_active(act[2]), .tx_done(done[2]));

  uart_tx_cfg #(.FREQUENCY(FREQ), .BAUD_RATE(BAUD), .DATA_BITS(9), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid[3]), .tx_data(data[3]),
    .tx_ready(rdy[3]), .fifo_count(cnt[3]), .tx_serial(ser[3]),
    .tx_active(act[3]), .tx_done(done[3]));

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Offer one word for exactly one edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input int inst, input logic [8:0] word);
    @(posedge clk); #1;
    valid[inst] = 1'b1;
    data[inst]  = word;
    @(posedge clk); #1;
    valid[inst] = 1'b0;
    data[inst]  = 9'h1FF;
  endtask

  // Push one word into an idle instance and check the frame cycle by cycle.
  task automatic runFrame(input vec_t v, input int id);
    int len;
    int k;
    int c;
    len = v.nbits * CPB;
    applyStimulus(v.inst, v.word);
    for (int e = 1; e <= len + 3; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        checkOutput($sformatf("v%0d_line_before_start", id), 16'(ser[v.inst]), 16'd1);
        checkOutput($sformatf("v%0d_active_before_start", id), 16'(act[v.inst]), 16'd0);
      end else if (e <= len + 1) begin
        k = (e - 2) / CPB;
        c = (e - 2) % CPB;
        if (c == 0 || c == CPB - 1)
          checkOutput($sformatf("v%0d_bit%0d_c%0d", id, k, c), 16'(ser[v.inst]), 16'(v.frame[k]));
        if (e == 2 || e == len + 1)
          checkOutput($sformatf("v%0d_active_e%0d", id, e), 16'(act[v.inst]), 16'd1);
        if (e == len + 1)
          checkOutput($sformatf("v%0d_done_early", id), 16'(done[v.inst]), 16'd0);
      end else if (e == len + 2) begin
        checkOutput($sformatf("v%0d_done_pulse", id), 16'(done[v.inst]), 16'd1);
        checkOutput($sformatf("v%0d_active_end", id), 16'(act[v.inst]), 16'd0);
        checkOutput($sformatf("v%0d_line_idle", id), 16'(ser[v.inst]), 16'd1);
      end else begin
        checkOutput($sformatf("v%0d_done_width", id), 16'(done[v.inst]), 16'd0);
      end
    end
  endtask

  // Bounded wait until instance A is idle with an empty FIFO.
  task automatic waitIdleA(input string name, input int budget);
    int t;
    t = 0;
    while (!(act[0] == 1'b0 && cnt[0] == 3'd0) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= budget) checkOutput({name, "_idle_timeout"}, 16'd0, 16'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference 8N1 decoder on instance A: mid-bit sampling, one word per frame.
  initial begin : monitor_a
    logic [7:0] w;
    w = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && ser[0] === 1'b0) begin
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          w[k] = ser[0];
        end
        repeat (CPB) @(negedge clk);
        checkOutput("mon_stop_bit", 16'(ser[0]), 16'd1);
        mon_words[mon_wr % 64] = w;
        mon_wr++;
      end
    end
  end

  // Event counters for instance A: done pulses, active cycles and active rises.
  initial begin : counters_a
    logic prev_act;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (done[0] === 1'b1) done_cnt_a++;
      if (act[0] === 1'b1) act_hi_a++;
      if (act[0] === 1'b1 && prev_act == 1'b0) act_rise_a++;
      prev_act = (act[0] === 1'b1);
    end
  end

  initial begin : main
    vec_t vecs [8];
    vec_t v;
    int base_wr;
    int base_done;
    int base_hi;
    int base_rise;
    int t;
    bit taken;
    bit dropped;

    // frame bit k is sent k-th: start 0, data LSB-first, parity, stop ones
    vecs[0] = '{inst: 0, word: 9'h0A5, frame: 12'h34A, nbits: 10};
    vecs[1] = '{inst: 1, word: 9'h013, frame: 12'h726, nbits: 11};
    vecs[2] = '{inst: 2, word: 9'h013, frame: 12'h626, nbits: 11};
    vecs[3] = '{inst: 3, word: 9'h1FF, frame: 12'h7FE, nbits: 11};
    vecs[4] = '{inst: 0, word: 9'h000, frame: 12'h200, nbits: 10};
    vecs[5] = '{inst: 1, word: 9'h07F, frame: 12'h7FE, nbits: 11};
    vecs[6] = '{inst: 3, word: 9'h100, frame: 12'h600, nbits: 11};
    vecs[7] = '{inst: 2, word: 9'h000, frame: 12'h700, nbits: 11};

    valid   = '0;
    data    = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rst%0d_line", i), 16'(ser[i]), 16'd1);
      checkOutput($sformatf("rst%0d_active", i), 16'(act[i]), 16'd0);
      checkOutput($sformatf("rst%0d_done", i), 16'(done[i]), 16'd0);
      checkOutput($sformatf("rst%0d_ready", i), 16'(rdy[i]), 16'd1);
      checkOutput($sformatf("rst%0d_count", i), 16'(cnt[i]), 16'd0);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) runFrame(vecs[i], i);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("table_decoded_a5", 16'(mon_words[0]), 16'h00A5);
    checkOutput("table_decoded_00", 16'(mon_words[1]), 16'h0000);

    // Hold valid with 0x01..0x06: FIFO fills, frames run back to back.
    base_wr   = mon_wr;
    base_done = done_cnt_a;
    base_hi   = act_hi_a;
    base_rise = act_rise_a;
    @(posedge clk); #1;
    for (int w = 1; w <= 6; w++) begin
      valid[0] = 1'b1;
      data[0]  = 9'(w);
      taken    = 1'b0;
      t        = 0;
      while (!taken && t < 1000) begin
        taken = rdy[0];
        @(posedge clk); #1;
        t++;
      end
      if (!taken) checkOutput($sformatf("fill_accept%0d_timeout", w), 16'd0, 16'd1);
      if (w == 5) begin
        checkOutput("fill_count_full", 16'(cnt[0]), 16'd4);
        checkOutput("fill_ready_low", 16'(rdy[0]), 16'd0);
      end
    end
    valid[0] = 1'b0;
    waitIdleA("fill", 1500);
    checkOutput("fill_done_pulses", 16'(done_cnt_a - base_done), 16'd6);
    checkOutput("fill_active_cycles", 16'(act_hi_a - base_hi), 16'd600);
    checkOutput("fill_active_rises", 16'(act_rise_a - base_rise), 16'd1);
    checkOutput("fill_final_count", 16'(cnt[0]), 16'd0);
    checkOutput("fill_frames", 16'(mon_wr - base_wr), 16'd6);
    for (int j = 0; j < 6; j++)
      checkOutput($sformatf("fill_word%0d", j), 16'(mon_words[(base_wr + j) % 64]), 16'(j + 1));

    // Pushes landing on the edges where the FSM pops.
    base_wr = mon_wr;
    @(posedge clk); #1;
    valid[0] = 1'b1;
    data[0]  = 9'h03C;
    @(posedge clk); #1;
    data[0]  = 9'h0C3;
    checkOutput("same_edge_count_first", 16'(cnt[0]), 16'd1);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    data[0]  = 9'h0FF;
    checkOutput("same_edge_count_idle_pop", 16'(cnt[0]), 16'd1);
    repeat (99) @(posedge clk);
    #1;
    checkOutput("same_edge_count_before_stop", 16'(cnt[0]), 16'd1);
    valid[0] = 1'b1;
    data[0]  = 9'h05A;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    data[0]  = 9'h0FF;
    checkOutput("same_edge_count_stop_pop", 16'(cnt[0]), 16'd1);
    waitIdleA("same_edge", 800);
    checkOutput("same_edge_frames", 16'(mon_wr - base_wr), 16'd3);
    checkOutput("same_edge_word0", 16'(mon_words[base_wr % 64]), 16'h003C);
    checkOutput("same_edge_word1", 16'(mon_words[(base_wr + 1) % 64]), 16'h00C3);
    checkOutput("same_edge_word2", 16'(mon_words[(base_wr + 2) % 64]), 16'h005A);

    // Reset at data bit 3 with two words queued.
    @(posedge clk); #1;
    valid[0] = 1'b1;
    data[0]  = 9'h011;
    @(posedge clk); #1;
    data[0]  = 9'h022;
    @(posedge clk); #1;
    data[0]  = 9'h033;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    checkOutput("rst_mid_queued", 16'(cnt[0]), 16'd2);
    repeat (42) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("rst_mid_line", 16'(ser[0]), 16'd1);
    checkOutput("rst_mid_active", 16'(act[0]), 16'd0);
    checkOutput("rst_mid_count", 16'(cnt[0]), 16'd0);
    checkOutput("rst_mid_ready", 16'(rdy[0]), 16'd1);
    base_done = done_cnt_a;
    dropped   = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (ser[0] !== 1'b1 || act[0] !== 1'b0) dropped = 1'b1;
    end
    checkOutput("rst_mid_line_stays_idle", 16'(dropped), 16'd0);
    checkOutput("rst_mid_no_done", 16'(done_cnt_a - base_done), 16'd0);
    v = '{inst: 0, word: 9'h096, frame: 12'h32C, nbits: 10};
    runFrame(v, 8);
    checkOutput("rst_mid_after_word", 16'(mon_words[(mon_wr - 1) % 64]), 16'h0096);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
